// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Brief    : Shared types and constants for the PC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } state_t;

    // Ordered so that a numerically larger cause has higher priority.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2,
        TRAP   = 2'd3
    } redirect_t;

    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_incrementer.sv
`default_nettype none
// ============================================================================
// Module   : pc_incrementer
// Brief    : Combinational sequential-fetch address (pc + INSTR_BYTES).
// Revision : 1.0 - initial release
// ============================================================================
module pc_incrementer
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'(INSTR_BYTES);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter controller with fetch handshake, redirects,
//            stall-held redirect latch, trap entry and halt/resume.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap,
    input  logic        halt,
    input  logic        resume,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        halted
);

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_epc, w_epc_next;
    logic        r_pend_valid, w_pend_valid_next;
    redirect_t   r_pend_cause, w_pend_cause_next;
    logic [31:0] r_pend_target, w_pend_target_next;
    logic        r_halted;

    redirect_t   w_req_cause;
    logic [31:0] w_req_target;
    logic [31:0] w_accept_pc;
    logic [31:0] w_pc_plus4;

    pc_incrementer u_incr (
        .pc       (r_pc),
        .pc_plus4 (w_pc_plus4)
    );

    // Highest-priority non-trap redirect requested this cycle.
    always_comb begin
        w_req_cause  = NONE;
        w_req_target = 32'h0;
        if (jump) begin
            w_req_cause  = JUMP;
            w_req_target = align_target(jump_target);
        end else if (branch_taken) begin
            w_req_cause  = BRANCH;
            w_req_target = align_target(branch_target);
        end
    end

    // Address loaded on an accepting edge: live redirect beats the latch.
    always_comb begin
        if (w_req_cause != NONE)
            w_accept_pc = w_req_target;
        else if (r_pend_valid)
            w_accept_pc = r_pend_target;
        else
            w_accept_pc = w_pc_plus4;
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_epc_next         = r_epc;
        w_pend_valid_next  = r_pend_valid;
        w_pend_cause_next  = r_pend_cause;
        w_pend_target_next = r_pend_target;

        case (r_state)
            BOOT: w_state_next = FETCH;

            FETCH, WAIT: begin
                if (trap) begin
                    // Outstanding fetch is abandoned; no handshake needed.
                    w_pc_next         = TRAP_VECTOR;
                    w_epc_next        = r_pc;
                    w_pend_valid_next = 1'b0;
                    w_pend_cause_next = NONE;
                    w_state_next      = (imem_ready && halt) ? HALTED : FETCH;
                end else if (imem_ready) begin
                    w_pc_next         = w_accept_pc;
                    w_pend_valid_next = 1'b0;
                    w_pend_cause_next = NONE;
                    w_state_next      = halt ? HALTED : FETCH;
                end else begin
                    w_state_next = WAIT;
                    if ((w_req_cause != NONE) &&
                        (!r_pend_valid || (w_req_cause >= r_pend_cause))) begin
                        w_pend_valid_next  = 1'b1;
                        w_pend_cause_next  = w_req_cause;
                        w_pend_target_next = w_req_target;
                    end
                end
            end

            HALTED: begin
                if (trap) begin
                    w_pc_next    = TRAP_VECTOR;
                    w_epc_next   = r_pc;
                    w_state_next = FETCH;
                end else if (resume) begin
                    w_state_next = FETCH;
                end
            end

            default: w_state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_epc         <= 32'h0;
            r_pend_valid  <= 1'b0;
            r_pend_cause  <= NONE;
            r_pend_target <= 32'h0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_epc         <= w_epc_next;
            r_pend_valid  <= w_pend_valid_next;
            r_pend_cause  <= w_pend_cause_next;
            r_pend_target <= w_pend_target_next;
            r_halted      <= (w_state_next == HALTED);
        end
    end

    assign imem_req  = (r_state == FETCH) || (r_state == WAIT);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign epc       = r_epc;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Self-checking bench for pc_sequencer with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, imem_ready, branch_taken, jump, trap, halt, resume;
    logic [31:0] branch_target, jump_target;
    logic        imem_req, halted;
    logic [31:0] imem_addr, pc, pc_plus4, epc;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: mode 0 = booting, 1 = running (fetching or stalled), 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_epc, m_ptgt;
    int          m_prank;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .halt          (halt),
        .resume        (resume),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .epc           (epc),
        .halted        (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] al(input logic [31:0] t);
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic model_edge();
        int nr;
        if (reset) begin
            m_mode = 0; m_pc = 32'h0; m_epc = 32'h0; m_prank = 0; m_ptgt = 32'h0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (trap) begin
                m_epc = m_pc; m_pc = 32'h80; m_prank = 0;
                m_mode = (imem_ready && halt) ? 2 : 1;
            end else if (imem_ready) begin
                if (jump)              m_pc = al(jump_target);
                else if (branch_taken) m_pc = al(branch_target);
                else if (m_prank != 0) m_pc = m_ptgt;
                else                   m_pc = m_pc + 32'd4;
                m_prank = 0;
                m_mode  = halt ? 2 : 1;
            end else begin
                nr = jump ? 2 : (branch_taken ? 1 : 0);
                if (nr != 0 && nr >= m_prank) begin
                    m_prank = nr;
                    m_ptgt  = jump ? al(jump_target) : al(branch_target);
                end
            end
        end else begin
            if (trap) begin
                m_epc = m_pc; m_pc = 32'h80; m_mode = 1;
            end else if (resume) begin
                m_mode = 1;
            end
        end
    endtask

    // Called at a negedge; drives inputs, clocks one edge, returns at the next negedge.
    task automatic step(input bit rs, input bit rdy, input bit br, input logic [31:0] bt,
                        input bit j, input logic [31:0] jt, input bit tr, input bit h,
                        input bit res);
        reset = rs; imem_ready = rdy; branch_taken = br; branch_target = bt;
        jump = j; jump_target = jt; trap = tr; halt = h; resume = res;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_req",  {31'h0, imem_req}, {31'h0, m_mode == 1});
            check("imem_addr", imem_addr, m_pc);
            check("pc",        pc,        m_pc);
            check("pc_plus4",  pc_plus4,  m_pc + 32'd4);
            check("epc",       epc,       m_epc);
            check("halted",    {31'h0, halted}, {31'h0, m_mode == 2});
        end
    end

    initial begin
        bit rs, rdy, br, j, tr, h, res;
        @(negedge clk);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lit_reset_pc",     pc,       32'h0);
        check("lit_reset_plus4",  pc_plus4, 32'h4);
        check("lit_reset_req",    {31'h0, imem_req}, 32'h0);
        check("lit_reset_halted", {31'h0, halted},   32'h0);
        check("lit_reset_epc",    epc,      32'h0);

        // BOOT cycle, then sequential fetches.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lit_boot_req",  {31'h0, imem_req}, 32'h1);
        check("lit_addr0",     imem_addr, 32'h0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lit_addr4",     imem_addr, 32'h4);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lit_addr8",     imem_addr, 32'h8);

        // Branch held across a 3-cycle stall.
        step(0, 0, 1, 32'h100, 0, 0, 0, 0, 0);
        check("lit_stall_hold", pc, 32'h8);
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        check("lit_stall_hold3", pc, 32'h8);
        step(0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        check("lit_pend_apply", pc, 32'h100);

        // Jump beats branch; low target bits dropped; trap beats both.
        step(0, 1, 1, 32'h300, 1, 32'h203, 0, 0, 0);
        check("lit_jump_prio", pc, 32'h200);
        step(0, 1, 1, 32'h300, 1, 32'h400, 1, 0, 0);
        check("lit_trap_pc",  pc,  32'h80);
        check("lit_trap_epc", epc, 32'h200);

        // Wrap-around.
        step(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        check("lit_wrap_plus4", pc_plus4, 32'h0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lit_wrap_pc", pc, 32'h0);

        // Halt at 0x40, then resume.
        step(0, 1, 0, 0, 1, 32'h40, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0);
        check("lit_halt_pc",     pc, 32'h44);
        check("lit_halt_flag",   {31'h0, halted},   32'h1);
        check("lit_halt_req",    {31'h0, imem_req}, 32'h0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lit_halt_stays",  {31'h0, halted},   32'h1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1);
        check("lit_resume_req",  {31'h0, imem_req}, 32'h1);
        check("lit_resume_pc",   pc, 32'h44);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lit_resume_next", pc, 32'h48);

        // Reset during a stall with a pending jump discards it.
        step(0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lit_rst_wait_pc", pc, 32'h0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lit_rst_no_pend", pc, 32'h4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            br  = ($urandom_range(0, 9) < 2);
            j   = ($urandom_range(0, 9) == 0);
            tr  = ($urandom_range(0, 39) == 0) && (m_mode != 0);
            h   = ($urandom_range(0, 19) == 0);
            res = ($urandom_range(0, 3) == 0);
            step(rs, rdy, br, $urandom, j, $urandom, tr, h, res);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
